// File: rtl/cache_arb_pkg.sv
// Shared types and defaults for the cache/main-memory arbiter.
//   arb_state_t : arbiter sequencing states
//   owner_t     : which cache owns the current line transfer
//   WORDS_PER_LINE_DEF : default number of words per cache line
package cache_arb_pkg;

   localparam int unsigned WORDS_PER_LINE_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WB   = 2'd1,
      FILL = 2'd2,
      DONE = 2'd3
   } arb_state_t;

   typedef enum logic {
      OWN_IC = 1'b0,
      OWN_DC = 1'b1
   } owner_t;

endpackage

// File: rtl/line_word_counter.sv
// Word sequencer for one line transfer.
//   CLK, RST  : clock, synchronous active-high reset
//   load      : restart at load_off with zero words transferred (wins over inc)
//   load_off  : starting word offset
//   inc       : one word transferred; offset wraps modulo WORDS_PER_LINE
//   word      : current word offset
//   last      : current word is the final one of the line (count based)
module line_word_counter
   import cache_arb_pkg::*;
#(
   parameter  int unsigned WORDS_PER_LINE = WORDS_PER_LINE_DEF,
   localparam int unsigned WOFF_W         = $clog2(WORDS_PER_LINE)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              load,
   input  logic [WOFF_W-1:0] load_off,
   input  logic              inc,
   output logic [WOFF_W-1:0] word,
   output logic              last
);

   logic [WOFF_W-1:0] word_q, word_d;
   logic [WOFF_W-1:0] xfer_q, xfer_d;

   // Offset and transferred-word count advance together; offset wraps naturally.
   always_comb begin
      word_d = word_q;
      xfer_d = xfer_q;
      if (load) begin
         word_d = load_off;
         xfer_d = '0;
      end else if (inc) begin
         word_d = word_q + WOFF_W'(1);
         xfer_d = xfer_q + WOFF_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         word_q <= '0;
         xfer_q <= '0;
      end else begin
         word_q <= word_d;
         xfer_q <= xfer_d;
      end
   end

   assign word = word_q;
   // Completion is judged on words moved, not offset, so critical-word-first wraps work.
   assign last = (xfer_q == WOFF_W'(WORDS_PER_LINE - 1));

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one main-memory port between I-cache and D-cache line fills, with an
// optional D-cache dirty-victim writeback ahead of the fill.
// Optional feature macro: CACHE_ARB_CRIT_WORD_FIRST_EN (fill starts at miss word).
//   CLK, RST                 : clock, synchronous active-high reset
//   ic_req/ic_addr           : I-cache line request (held until ic_done)
//   ic_rvalid/ic_word/ic_rdata/ic_done : I-cache fill word stream and completion
//   dc_req/dc_addr/dc_wb/dc_wb_addr    : D-cache request, victim writeback control
//   dc_wdata                 : victim word selected by dc_word
//   dc_word/dc_rvalid/dc_rdata/dc_done : D-cache word index, fill stream, completion
//   mem_addr/mem_rd/mem_we/mem_wdata   : memory request, held until mem_valid
//   mem_rdata/mem_valid      : memory response / write accept
module cache_mem_arbiter
   import cache_arb_pkg::*;
#(
   parameter  int unsigned WORDS_PER_LINE = WORDS_PER_LINE_DEF,
   parameter  int unsigned ADDR_W         = 32,
   parameter  int unsigned DATA_W         = 32,
   localparam int unsigned WOFF_W         = $clog2(WORDS_PER_LINE)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              ic_req,
   input  logic [ADDR_W-1:0] ic_addr,
   output logic              ic_rvalid,
   output logic [WOFF_W-1:0] ic_word,
   output logic [DATA_W-1:0] ic_rdata,
   output logic              ic_done,
   input  logic              dc_req,
   input  logic [ADDR_W-1:0] dc_addr,
   input  logic              dc_wb,
   input  logic [ADDR_W-1:0] dc_wb_addr,
   input  logic [DATA_W-1:0] dc_wdata,
   output logic [WOFF_W-1:0] dc_word,
   output logic              dc_rvalid,
   output logic [DATA_W-1:0] dc_rdata,
   output logic              dc_done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_valid
);

   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(WORDS_PER_LINE * 4 - 1);

   arb_state_t        state_q, state_d;
   owner_t            owner_q, owner_d;
   owner_t            last_grant_q, last_grant_d;
   logic [ADDR_W-1:0] wb_base_q, wb_base_d;
   logic [ADDR_W-1:0] fill_base_q, fill_base_d;
   logic [WOFF_W-1:0] fill_off_q, fill_off_d;

   owner_t            pick;
   logic [ADDR_W-1:0] req_addr;
   logic              cnt_load;
   logic [WOFF_W-1:0] cnt_off;
   logic              cnt_inc;
   logic [WOFF_W-1:0] cnt_word;
   logic              cnt_last;

   line_word_counter #(
      .WORDS_PER_LINE (WORDS_PER_LINE)
   ) u_cnt (
      .CLK      (CLK),
      .RST      (RST),
      .load     (cnt_load),
      .load_off (cnt_off),
      .inc      (cnt_inc),
      .word     (cnt_word),
      .last     (cnt_last)
   );

   // Next-state: arbitration in IDLE, word sequencing in WB/FILL.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      wb_base_d    = wb_base_q;
      fill_base_d  = fill_base_q;
      fill_off_d   = fill_off_q;
      pick         = OWN_IC;
      req_addr     = ic_addr;
      cnt_load     = 1'b0;
      cnt_off      = '0;
      cnt_inc      = 1'b0;

      case (state_q)
         IDLE: begin
            if (ic_req || dc_req) begin
               // On a tie the cache that was not granted last time wins.
               if (ic_req && dc_req) begin
                  pick = (last_grant_q == OWN_IC) ? OWN_DC : OWN_IC;
               end else if (dc_req) begin
                  pick = OWN_DC;
               end
               req_addr     = (pick == OWN_DC) ? dc_addr : ic_addr;
               owner_d      = pick;
               last_grant_d = pick;
               fill_base_d  = req_addr & ~OFF_MASK;
`ifdef CACHE_ARB_CRIT_WORD_FIRST_EN
               fill_off_d   = req_addr[WOFF_W+1:2];
`else
               fill_off_d   = '0;
`endif
               cnt_load     = 1'b1;
               if ((pick == OWN_DC) && dc_wb) begin
                  wb_base_d = dc_wb_addr & ~OFF_MASK;
                  cnt_off   = '0;
                  state_d   = WB;
               end else begin
                  cnt_off   = fill_off_d;
                  state_d   = FILL;
               end
            end
         end
         WB: begin
            if (mem_valid) begin
               cnt_inc = 1'b1;
               if (cnt_last) begin
                  cnt_load = 1'b1;
                  cnt_off  = fill_off_q;
                  state_d  = FILL;
               end
            end
         end
         FILL: begin
            if (mem_valid) begin
               cnt_inc = 1'b1;
               if (cnt_last) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= IDLE;
         owner_q      <= OWN_IC;
         last_grant_q <= OWN_IC;
         wb_base_q    <= '0;
         fill_base_q  <= '0;
         fill_off_q   <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         wb_base_q    <= wb_base_d;
         fill_base_q  <= fill_base_d;
         fill_off_q   <= fill_off_d;
      end
   end

   // Output decode; only the fill data path and write data pass straight through.
   always_comb begin
      ic_rvalid = 1'b0;
      ic_word   = '0;
      ic_rdata  = '0;
      ic_done   = 1'b0;
      dc_word   = '0;
      dc_rvalid = 1'b0;
      dc_rdata  = '0;
      dc_done   = 1'b0;
      mem_addr  = '0;
      mem_rd    = 1'b0;
      mem_we    = 1'b0;
      mem_wdata = '0;

      case (state_q)
         WB: begin
            mem_we    = 1'b1;
            mem_wdata = dc_wdata;
            mem_addr  = wb_base_q + ADDR_W'({cnt_word, 2'b00});
            dc_word   = cnt_word;
         end
         FILL: begin
            mem_rd   = 1'b1;
            mem_addr = fill_base_q + ADDR_W'({cnt_word, 2'b00});
            if (owner_q == OWN_DC) begin
               dc_word   = cnt_word;
               dc_rvalid = mem_valid;
               dc_rdata  = mem_valid ? mem_rdata : '0;
            end else begin
               ic_word   = cnt_word;
               ic_rvalid = mem_valid;
               ic_rdata  = mem_valid ? mem_rdata : '0;
            end
         end
         DONE: begin
            if (owner_q == OWN_DC) begin
               dc_done = 1'b1;
            end else begin
               ic_done = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed table, corner sequences,
// randomized requests against a transaction-level model of line transfers.
module tb_cache_mem_arbiter;

   localparam int unsigned N = 8;
`ifdef CACHE_ARB_CRIT_WORD_FIRST_EN
   localparam bit CWF = 1'b1;
`else
   localparam bit CWF = 1'b0;
`endif

   logic        CLK, RST;
   logic        ic_req, dc_req, dc_wb;
   logic [31:0] ic_addr, dc_addr, dc_wb_addr, dc_wdata;
   logic        ic_rvalid, ic_done, dc_rvalid, dc_done;
   logic [2:0]  ic_word, dc_word;
   logic [31:0] ic_rdata, dc_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_rd, mem_we, mem_valid;

   cache_mem_arbiter dut (
      .CLK(CLK), .RST(RST),
      .ic_req(ic_req), .ic_addr(ic_addr), .ic_rvalid(ic_rvalid), .ic_word(ic_word),
      .ic_rdata(ic_rdata), .ic_done(ic_done),
      .dc_req(dc_req), .dc_addr(dc_addr), .dc_wb(dc_wb), .dc_wb_addr(dc_wb_addr),
      .dc_wdata(dc_wdata), .dc_word(dc_word), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
      .dc_done(dc_done),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_valid(mem_valid)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Victim line content as the D-cache would present it for a given word.
   assign dc_wdata = 32'hC0DE_0000 ^ dc_wb_addr ^ 32'(dc_word);

   typedef struct { bit we; logic [31:0] addr; logic [31:0] data; } acc_t;
   typedef struct { int unsigned word; logic [31:0] data; } fill_t;

   int checks = 0;
   int errors = 0;

   acc_t  obs_acc[$], exp_acc[$];
   fill_t obs_ic[$], exp_ic[$], obs_dc[$], exp_dc[$];
   bit    obs_done[$], exp_done[$];
   bit    lg_m;                 // model last grant: 1 = D-cache
   int    cyc_n = 0, last_rv_cyc = 0, last_done_cyc = 0;

   int gap_fixed = 0, gap_max = 0, wait_cnt = 0;
   bit spurious = 0;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   // ---------------- reference model ----------------
   function automatic logic [31:0] memdata(logic [31:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
   endfunction

   function automatic logic [31:0] line_base(logic [31:0] a);
      return a & ~32'h1F;
   endfunction

   function automatic int unsigned first_off(logic [31:0] a);
      return CWF ? ((a >> 2) % N) : 0;
   endfunction

   task automatic build_one(input bit is_dc, input logic [31:0] a, input bit wb,
                            input logic [31:0] wba);
      int unsigned w;
      logic [31:0] ad;
      if (is_dc && wb) begin
         for (int k = 0; k < N; k++) begin
            ad = line_base(wba) + 32'(k * 4);
            exp_acc.push_back('{we: 1'b1, addr: ad, data: 32'hC0DE_0000 ^ wba ^ 32'(k)});
         end
      end
      for (int k = 0; k < N; k++) begin
         w  = (first_off(a) + k) % N;
         ad = line_base(a) + 32'(w * 4);
         exp_acc.push_back('{we: 1'b0, addr: ad, data: memdata(ad)});
         if (is_dc) exp_dc.push_back('{word: w, data: memdata(ad)});
         else       exp_ic.push_back('{word: w, data: memdata(ad)});
      end
      exp_done.push_back(is_dc);
   endtask

   // ---------------- memory responder ----------------
   function automatic int next_gap();
      return (gap_fixed >= 0) ? gap_fixed : int'($urandom_range(0, gap_max));
   endfunction

   initial begin
      mem_valid = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge CLK); #1;
         if (mem_rd || mem_we) begin
            if (wait_cnt <= 0) begin
               mem_valid = 1'b1;
               mem_rdata = memdata(mem_addr);
               wait_cnt  = next_gap();
            end else begin
               mem_valid = 1'b0;
               mem_rdata = $urandom;
               wait_cnt--;
            end
         end else begin
            mem_valid = spurious && ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
         end
      end
   end

   // ---------------- monitor ----------------
   bit          prev_pend = 0, prev_rd = 0, prev_we = 0;
   logic [31:0] prev_addr = 0;

   always @(negedge CLK) begin
      cyc_n++;
      if (RST) begin
         prev_pend = 0;
      end else begin
         if (prev_pend) begin
            chk("hold rd", mem_rd, prev_rd);
            chk("hold we", mem_we, prev_we);
            chk("hold addr", mem_addr, prev_addr);
         end
         if (mem_valid && (mem_rd || mem_we))
            obs_acc.push_back('{we: mem_we, addr: mem_addr, data: (mem_we ? mem_wdata : mem_rdata)});
         if (ic_rvalid) begin obs_ic.push_back('{word: 32'(ic_word), data: ic_rdata}); last_rv_cyc = cyc_n; end
         if (dc_rvalid) begin obs_dc.push_back('{word: 32'(dc_word), data: dc_rdata}); last_rv_cyc = cyc_n; end
         if (ic_done) begin obs_done.push_back(1'b0); last_done_cyc = cyc_n; end
         if (dc_done) begin obs_done.push_back(1'b1); last_done_cyc = cyc_n; end
         prev_pend = (mem_rd || mem_we) && !mem_valid;
         prev_rd   = mem_rd;
         prev_we   = mem_we;
         prev_addr = mem_addr;
      end
   end

   // ---------------- transaction helpers ----------------
   task automatic clear_q();
      obs_acc.delete(); exp_acc.delete(); obs_ic.delete(); exp_ic.delete();
      obs_dc.delete(); exp_dc.delete(); obs_done.delete(); exp_done.delete();
   endtask

   task automatic compare(input string tag);
      chk({tag, " acc count"}, obs_acc.size(), exp_acc.size());
      for (int i = 0; i < exp_acc.size() && i < obs_acc.size(); i++) begin
         chk($sformatf("%s acc%0d we", tag, i), obs_acc[i].we, exp_acc[i].we);
         chk($sformatf("%s acc%0d addr", tag, i), obs_acc[i].addr, exp_acc[i].addr);
         chk($sformatf("%s acc%0d data", tag, i), obs_acc[i].data, exp_acc[i].data);
      end
      chk({tag, " ic fill count"}, obs_ic.size(), exp_ic.size());
      for (int i = 0; i < exp_ic.size() && i < obs_ic.size(); i++) begin
         chk($sformatf("%s ic%0d word", tag, i), obs_ic[i].word, exp_ic[i].word);
         chk($sformatf("%s ic%0d data", tag, i), obs_ic[i].data, exp_ic[i].data);
      end
      chk({tag, " dc fill count"}, obs_dc.size(), exp_dc.size());
      for (int i = 0; i < exp_dc.size() && i < obs_dc.size(); i++) begin
         chk($sformatf("%s dc%0d word", tag, i), obs_dc[i].word, exp_dc[i].word);
         chk($sformatf("%s dc%0d data", tag, i), obs_dc[i].data, exp_dc[i].data);
      end
      chk({tag, " done count"}, obs_done.size(), exp_done.size());
      for (int i = 0; i < exp_done.size() && i < obs_done.size(); i++)
         chk($sformatf("%s done%0d owner", tag, i), obs_done[i], exp_done[i]);
   endtask

   task automatic serve(input bit ic, input logic [31:0] ica, input bit dc,
                        input logic [31:0] dca, input bit wb, input logic [31:0] wba,
                        input string tag);
      bit dc_first, ic_seen, dc_seen;
      int cyc;
      clear_q();
      dc_first = dc && (!ic || !lg_m);
      if (dc_first) begin
         build_one(1'b1, dca, wb, wba);
         if (ic) build_one(1'b0, ica, 1'b0, 32'h0);
      end else begin
         build_one(1'b0, ica, 1'b0, 32'h0);
         if (dc) build_one(1'b1, dca, wb, wba);
      end
      lg_m = (ic && dc) ? !dc_first : dc;

      @(posedge CLK); #1;
      ic_req = ic; ic_addr = ica; dc_req = dc; dc_addr = dca; dc_wb = wb; dc_wb_addr = wba;
      ic_seen = 0; dc_seen = 0; cyc = 0;
      while ((ic_req || dc_req) && cyc < 2000) begin
         @(posedge CLK); #1;
         cyc++;
         foreach (obs_done[i]) begin
            if (obs_done[i]) dc_seen = 1; else ic_seen = 1;
         end
         if (ic_seen) ic_req = 1'b0;
         if (dc_seen) dc_req = 1'b0;
      end
      if (ic_req || dc_req) begin
         chk({tag, " timeout"}, 1, 0);
         ic_req = 1'b0; dc_req = 1'b0;
      end
      repeat (3) @(posedge CLK);
      #1;
      compare(tag);
   endtask

   task automatic do_reset();
      RST = 1'b1; ic_req = 1'b0; dc_req = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b0;
      lg_m = 1'b0;
   endtask

   function automatic logic [1:0] first_done();
      return (obs_done.size() > 0) ? {1'b0, obs_done[0]} : 2'd2;
   endfunction

   function automatic logic [31:0] first_addr();
      return (obs_acc.size() > 0) ? obs_acc[0].addr : 32'hDEAD_BEEF;
   endfunction

   // ---------------- directed vectors ----------------
   typedef struct {
      bit ic; logic [31:0] ica; bit dc; logic [31:0] dca; bit wb; logic [31:0] wba;
      logic [31:0] exp_first_addr; bit exp_first_we; int exp_nacc; bit exp_first_dc;
   } vec_t;

   vec_t vec [5];

   initial begin
      int cyc;
      vec[0] = '{1, 32'h104, 0, 32'h0, 0, 32'h0, (CWF ? 32'h104 : 32'h100), 0, 8, 0};
      vec[1] = '{0, 32'h0, 1, 32'h340, 1, 32'h200, 32'h200, 1, 16, 1};
      vec[2] = '{0, 32'h0, 1, 32'h3514, 0, 32'h0, (CWF ? 32'h3514 : 32'h3500), 0, 8, 1};
      vec[3] = '{1, 32'h7FC, 0, 32'h0, 0, 32'h0, (CWF ? 32'h7FC : 32'h7E0), 0, 8, 0};
      vec[4] = '{1, 32'h20, 1, 32'h44, 0, 32'h0, (CWF ? 32'h44 : 32'h40), 0, 16, 1};

      RST = 1'b1; ic_req = 0; dc_req = 0; dc_wb = 0;
      ic_addr = 0; dc_addr = 0; dc_wb_addr = 0; lg_m = 0;
      repeat (2) @(posedge CLK);
      @(negedge CLK); #1;
      chk("rst ic_rvalid", ic_rvalid, 0); chk("rst ic_word", ic_word, 0);
      chk("rst ic_rdata", ic_rdata, 0);   chk("rst ic_done", ic_done, 0);
      chk("rst dc_word", dc_word, 0);     chk("rst dc_rvalid", dc_rvalid, 0);
      chk("rst dc_rdata", dc_rdata, 0);   chk("rst dc_done", dc_done, 0);
      chk("rst mem_addr", mem_addr, 0);   chk("rst mem_rd", mem_rd, 0);
      chk("rst mem_we", mem_we, 0);       chk("rst mem_wdata", mem_wdata, 0);
      RST = 1'b0;

      gap_fixed = 0; spurious = 0;
      for (int v = 0; v < 5; v++) begin
         serve(vec[v].ic, vec[v].ica, vec[v].dc, vec[v].dca, vec[v].wb, vec[v].wba,
               $sformatf("vec%0d", v));
         chk($sformatf("vec%0d first addr", v), first_addr(), vec[v].exp_first_addr);
         chk($sformatf("vec%0d first we", v), (obs_acc.size() > 0) ? obs_acc[0].we : 1'bx,
             vec[v].exp_first_we);
         chk($sformatf("vec%0d nacc", v), obs_acc.size(), vec[v].exp_nacc);
         chk($sformatf("vec%0d first owner", v), first_done(), {1'b0, vec[v].exp_first_dc});
         chk($sformatf("vec%0d done latency", v), last_done_cyc - last_rv_cyc, 1);
      end

      // Tie right after reset goes to D-cache; later ties go to whoever was not last.
      do_reset();
      serve(1, 32'h104, 1, 32'h340, 0, 32'h0, "tie1");
      chk("tie1 first owner dc", first_done(), 2'd1);
      serve(0, 32'h0, 1, 32'h3514, 0, 32'h0, "dc_alone");
      serve(1, 32'h104, 1, 32'h340, 0, 32'h0, "tie2");
      chk("tie2 first owner ic", first_done(), 2'd0);

      // Slow memory: requests must hold across 3-cycle response gaps.
      gap_fixed = 3;
      serve(0, 32'h0, 1, 32'h3514, 0, 32'h0, "gap");
      chk("gap first addr", first_addr(), CWF ? 32'h3514 : 32'h3500);
      chk("gap first word", (obs_dc.size() > 0) ? obs_dc[0].word : 99, CWF ? 5 : 0);

      // Reset during the fourth fill word aborts without a done pulse.
      gap_fixed = 0;
      do_reset();
      clear_q();
      @(posedge CLK); #1;
      ic_req = 1'b1; ic_addr = 32'h104;
      cyc = 0;
      while (obs_ic.size() < 4 && cyc < 200) begin
         @(negedge CLK); #1;
         cyc++;
      end
      chk("rstmid reached word3", obs_ic.size(), 4);
      RST = 1'b1; ic_req = 1'b0;
      @(negedge CLK); #1;
      chk("rstmid mem_rd", mem_rd, 0);
      chk("rstmid ic_rvalid", ic_rvalid, 0);
      chk("rstmid ic_done", ic_done, 0);
      chk("rstmid mem_addr", mem_addr, 0);
      RST = 1'b0; lg_m = 1'b0;
      obs_acc.delete(); obs_done.delete();
      repeat (6) @(negedge CLK);
      #1;
      chk("rstmid no done", obs_done.size(), 0);
      chk("rstmid no access", obs_acc.size(), 0);
      serve(1, 32'h104, 0, 32'h0, 0, 32'h0, "after_rst");

      // Random traffic with random memory latency and stray mem_valid while idle.
      spurious = 1;
      gap_fixed = -1;
      for (int t = 0; t < 40; t++) begin
         bit ri, rdc;
         ri  = 1'($urandom_range(0, 1));
         rdc = 1'($urandom_range(0, 1));
         if (!ri && !rdc) ri = 1'b1;
         gap_max = $urandom_range(0, 3);
         serve(ri, $urandom, rdc, $urandom, 1'($urandom_range(0, 1)), $urandom,
               $sformatf("rand%0d", t));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
